// File: rtl/spi_master_pkg.sv
// spi_master_pkg: CS FSM state encoding and SPI mode decode helpers
package spi_master_pkg;
  typedef enum logic [1:0] {IDLE, TRANSFER, CS_INACTIVE} state_t;
  function automatic logic cpol(input int mode);
    return (mode & 2) != 0;
  endfunction
  function automatic logic cpha(input int mode);
    return (mode & 1) != 0;
  endfunction
endpackage

// File: rtl/spi_master_byte.sv
// spi_master_byte: single-byte full-duplex SPI engine with SCLK generation and shift registers
// Bit order is LSB first when SPI_MASTER_LSB_FIRST_EN is defined, MSB first otherwise.
module spi_master_byte
  import spi_master_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_dv,
  output logic       tx_ready,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       spi_clk,
  input  logic       miso,
  output logic       mosi
);
  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);
  localparam int HW = $clog2(2 * CLKS_PER_HALF_BIT);
`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic out_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] tx_next(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
  function automatic logic [7:0] rx_next(input logic [7:0] b, input logic d);
    return {d, b[7:1]};
  endfunction
`else
  function automatic logic out_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] tx_next(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
  function automatic logic [7:0] rx_next(input logic [7:0] b, input logic d);
    return {b[6:0], d};
  endfunction
`endif
  logic [HW-1:0] clk_cnt;
  logic [4:0] edge_cnt;
  logic [7:0] tx_sr, rx_sr;
  logic [2:0] rx_cnt;
  logic lead, trail, shift, sample;
  assign lead   = edge_cnt != 0 && clk_cnt == HW'(CLKS_PER_HALF_BIT - 1);
  assign trail  = edge_cnt != 0 && clk_cnt == HW'(2 * CLKS_PER_HALF_BIT - 1);
  assign shift  = CPHA ? lead : trail;
  assign sample = CPHA ? trail : lead;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_ready <= 1'b0;
      edge_cnt <= '0;
      clk_cnt  <= '0;
      spi_clk  <= CPOL;
      mosi     <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_cnt   <= '0;
      rx_dv    <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_dv <= 1'b0;
      if (tx_dv && tx_ready) begin
        tx_ready <= 1'b0;
        edge_cnt <= 5'd16;
        clk_cnt  <= '0;
        rx_cnt   <= '0;
        tx_sr    <= CPHA ? tx_byte : tx_next(tx_byte);
        mosi     <= CPHA ? mosi : out_bit(tx_byte);
      end else if (edge_cnt != 0) begin
        clk_cnt <= trail ? '0 : clk_cnt + 1'b1;
        if (lead || trail) begin
          edge_cnt <= edge_cnt - 1'b1;
          spi_clk  <= ~spi_clk;
        end
        if (shift) begin
          mosi  <= out_bit(tx_sr);
          tx_sr <= tx_next(tx_sr);
        end
        if (sample) begin
          rx_sr  <= rx_next(rx_sr, miso);
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 3'd7) begin
            rx_dv   <= 1'b1;
            rx_byte <= rx_next(rx_sr, miso);
          end
        end
      end else begin
        tx_ready <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_master_maquina_estats_mlf.sv
// spi_master_maquina_estats_mlf: SPI master with CS burst FSM around a byte engine
// Bit order selectable with SPI_MASTER_LSB_FIRST_EN (handled inside the byte engine).
module spi_master_maquina_estats_mlf
  import spi_master_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CW-1:0] i_TX_count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_SPI_clk,
  input  logic          i_SPI_MISO,
  output logic          o_SPI_MOSI,
  output logic          o_SPI_CS_n
);
  localparam int IW = $clog2(CS_INACTIVE_CLKS + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] inact, inact_nxt;
  logic cs_nxt, eng_ready, eng_dv, accept_ok;
  assign accept_ok  = eng_ready && (state == IDLE || (state == TRANSFER && cnt != '0));
  assign eng_dv     = i_TX_DV && accept_ok;
  assign o_TX_Ready = !i_TX_DV && accept_ok;
  spi_master_byte #(
    .SPI_MODE(SPI_MODE),
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_byte (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .tx_byte(i_TX_Byte),
    .tx_dv(eng_dv),
    .tx_ready(eng_ready),
    .rx_dv(o_RX_DV),
    .rx_byte(o_RX_Byte),
    .spi_clk(o_SPI_clk),
    .miso(i_SPI_MISO),
    .mosi(o_SPI_MOSI)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inact_nxt = inact;
    cs_nxt    = o_SPI_CS_n;
    if (state == IDLE && eng_dv) begin
      cs_nxt    = 1'b0;
      cnt_nxt   = (i_TX_count == '0) ? '0 : i_TX_count - 1'b1;
      state_nxt = TRANSFER;
    end else if (state == TRANSFER && eng_dv) begin
      cnt_nxt = cnt - 1'b1;
    end else if (state == TRANSFER && eng_ready && cnt == '0) begin
      cs_nxt    = 1'b1;
      inact_nxt = IW'(CS_INACTIVE_CLKS);
      state_nxt = CS_INACTIVE;
    end else if (state == CS_INACTIVE) begin
      inact_nxt = inact - 1'b1;
      state_nxt = (inact <= IW'(1)) ? IDLE : CS_INACTIVE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      inact      <= '0;
      o_SPI_CS_n <= 1'b1;
      o_RX_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      inact      <= inact_nxt;
      o_SPI_CS_n <= cs_nxt;
      o_RX_count <= o_SPI_CS_n ? '0 : o_RX_count + CW'(o_RX_DV);
    end
  end
endmodule

// File: tb/tb_spi_master_maquina_estats_mlf.sv
// tb_spi_master_maquina_estats_mlf: scoreboard bench over four looped-back instances, one per SPI mode
module tb_spi_master_maquina_estats_mlf;
  localparam int H = 2;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam logic FIRST_01 = 1'b1;
`else
  localparam logic FIRST_01 = 1'b0;
`endif
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic [1:0] idx;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] tx_dv, ready, rx_dv, sclk, mosi, cs_n;
  logic [7:0] tx_byte;
  logic [1:0] tx_count;
  logic [7:0] rx_byte[4];
  logic [1:0] rx_cnt[4];
  int checks = 0;
  int errors = 0;
  int rises = 0;
  int r0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_maquina_estats_mlf #(
      .SPI_MODE(g),
      .CLKS_PER_HALF_BIT(H),
      .MAX_BYTES_PER_CS(2),
      .CS_INACTIVE_CLKS(3)
    ) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_TX_count(tx_count),
      .i_TX_Byte(tx_byte),
      .i_TX_DV(tx_dv[g]),
      .o_TX_Ready(ready[g]),
      .o_RX_count(rx_cnt[g]),
      .o_RX_DV(rx_dv[g]),
      .o_RX_Byte(rx_byte[g]),
      .o_SPI_clk(sclk[g]),
      .i_SPI_MISO(mosi[g]),
      .o_SPI_MOSI(mosi[g]),
      .o_SPI_CS_n(cs_n[g])
    );
  end
  always @(posedge cs_n[0]) rises++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m] === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected m%0d: got %0h expected no RX", m, rx_byte[m]);
        end else begin
          e = q.pop_front();
          chk($sformatf("rx_mode m%0d", m), 32'(m), 32'(e.mode));
          chk($sformatf("rx_byte m%0d", m), 32'(rx_byte[m]), 32'(e.data));
          chk($sformatf("rx_count m%0d", m), 32'(rx_cnt[m]), 32'(e.idx));
        end
      end
    end
  end
  task automatic wait_ready(input int m);
    int n = 0;
    while (ready[m] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready[m] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout m%0d: got 0 expected 1", m);
    end
  endtask
  task automatic send(input int m, input logic [7:0] b, input logic [1:0] c, input bit expect_rx,
                      input logic [1:0] idx);
    wait_ready(m);
    tx_byte  = b;
    tx_count = c;
    tx_dv[m] = 1'b1;
    if (expect_rx) q.push_back(exp_t'{2'(m), b, idx});
    @(negedge clk);
    tx_dv[m] = 1'b0;
  endtask
  task automatic sclk_shape(input int m);
    logic prev;
    int edges, last;
    bit ok;
    prev = sclk[m];
    edges = 0;
    last = 0;
    ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sclk[m] !== prev) begin
        if (edges > 0 && i - last != H) ok = 1'b0;
        last = i;
        edges++;
        prev = sclk[m];
      end
    end
    chk($sformatf("sclk_edges m%0d", m), edges, 16);
    chk($sformatf("sclk_spacing m%0d", m), 32'(ok), 1);
    chk($sformatf("sclk_end m%0d", m), 32'(sclk[m]), 32'(m >> 1));
  endtask
  task automatic cs_gap(input int m, input int exp);
    int n = 0;
    while (cs_n[m] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ready[m] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cs_high_clks", n, exp);
  endtask
  initial begin
    tx_dv = '0;
    tx_byte = '0;
    tx_count = '0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_cs m%0d", m), 32'(cs_n[m]), 1);
      chk($sformatf("rst_sclk m%0d", m), 32'(sclk[m]), 32'(m >> 1));
      chk($sformatf("rst_ready m%0d", m), 32'(ready[m]), 0);
      chk($sformatf("rst_rxcnt m%0d", m), 32'(rx_cnt[m]), 0);
    end
    chk("rst_mosi", 32'(mosi[0]), 0);
    chk("rst_rxdv", 32'(rx_dv[0]), 0);
    chk("rst_rxbyte", 32'(rx_byte[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rises;
    send(0, 8'h78, 2'd2, 1'b1, 2'd0);
    chk("mosi_first_78", 32'(mosi[0]), 0);
    send(0, 8'h9A, 2'd2, 1'b1, 2'd1);
    cs_gap(0, 3);
    chk("cs_rises_burst2", rises - r0, 1);
    for (int m = 1; m < 4; m++) begin
      chk($sformatf("sclk_idle m%0d", m), 32'(sclk[m]), 32'(m >> 1));
      send(m, 8'hA5, 2'd1, 1'b1, 2'd0);
      sclk_shape(m);
      wait_ready(m);
    end
    r0 = rises;
    send(0, 8'h3C, 2'd1, 1'b1, 2'd0);
    wait_ready(0);
    chk("rxcnt_after_single", 32'(rx_cnt[0]), 0);
    chk("cs_after_single", 32'(cs_n[0]), 1);
    chk("cs_rises_single", rises - r0, 1);
    r0 = rises;
    send(0, 8'h55, 2'd0, 1'b1, 2'd0);
    wait_ready(0);
    chk("cs_rises_count0", rises - r0, 1);
    send(0, 8'h01, 2'd1, 1'b1, 2'd0);
    chk("mosi_first_01", 32'(mosi[0]), 32'(FIRST_01));
    wait_ready(0);
    send(0, 8'hF0, 2'd1, 1'b0, 2'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs_n[0]), 1);
    chk("midrst_sclk", 32'(sclk[0]), 0);
    chk("midrst_mosi", 32'(mosi[0]), 0);
    chk("midrst_rxdv", 32'(rx_dv[0]), 0);
    chk("midrst_ready", 32'(ready[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h5A, 2'd1, 1'b1, 2'd0);
    wait_ready(0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
